fifo_uart_tx: RTL and testbench

//  Downstream drain stage for the byte FIFO. Pops one word whenever the FIFO is non-empty
//  and enabled, then serialises it as an asynchronous UART frame on tx.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/fifo_uart_tx.sv | 151 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default timing/width
// constants, used by fifo_uart_tx and the planned uart_rx.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] POP    = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] PARITY = 3'd5;
  localparam logic [2:0] STOP   = 3'd6;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_W       = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, pulses tick in the wrap cycle.
// Ports: clk, rst (sync, active-high), clr (sync clear), tick, cnt.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          tick,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word per frame and sends it as a UART frame
// (start, DATA_W bits LSB-first, optional even parity, stop bits) on tx.
// Ports: clk, rst (sync, active-high), enable, fifo_empty, fifo_data in;
//        fifo_pop, tx, busy, frame_done out (all registered).
// Optional feature: `define FIFO_UART_TX_PARITY_EN adds an even parity bit.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] PRE_WRAP  = CW'(CLKS_PER_BIT - 2);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              pop_q, pop_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              par_q, par_d;

  logic          tick;
  logic          baud_clr;
  logic [CW-1:0] baud_cnt;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick),
    .cnt (baud_cnt)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE:  if (enable && !fifo_empty) state_d = POP;
      POP:   state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
        bit_d   = '0;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        if (bit_q == LAST_BIT) begin
          bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) begin
        if (bit_q == LAST_STOP) begin
          bit_d   = '0;
          state_d = IDLE;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Restart the bit period on every state change and while loading.
  assign baud_clr = (state_d != state_q) || (state_q == LOAD);

`ifdef FIFO_UART_TX_PARITY_EN
  assign par_d = (state_q == LOAD) ? ^fifo_data : par_q;
`else
  assign par_d = 1'b0;
`endif

  // Outputs are decoded from the next state so they appear registered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign pop_d  = (state_d == POP);
  assign busy_d = (state_d != IDLE);
  // Raised one cycle early so the flop is high in the final stop cycle.
  assign done_d = (state_q == STOP) && (bit_q == LAST_STOP)
                  && (baud_cnt == PRE_WRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      par_q   <= par_d;
    end
  end

  assign fifo_pop   = pop_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed testbench for fifo_uart_tx (CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1).
// A queue models the FIFO: registered read data, empty flag from the queue.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_pop;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic [7:0] fq[$];
  int pops = 0;
  int tests = 0;
  int fails = 0;

  logic cap_tx[64];
  logic cap_fd[64];
  logic cap_busy[64];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_W      (8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always @(posedge clk) begin
    if (fifo_pop) begin
      pops <= pops + 1;
      if (fq.size() > 0) fifo_data <= fq.pop_front();
    end
  end

  always @(negedge clk) fifo_empty <= (fq.size() == 0);

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Value held for a whole bit period, or x if tx moved inside it.
  function automatic logic bit_seen(input int b);
    logic v;
    v = cap_tx[b*CPB];
    for (int k = 1; k < CPB; k++)
      if (cap_tx[b*CPB+k] !== v) return 1'bx;
    return v;
  endfunction

  function automatic int fd_count(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (cap_fd[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int fd_last(input int n);
    int p;
    p = -1;
    for (int i = 0; i < n; i++) if (cap_fd[i] === 1'b1) p = i;
    return p;
  endfunction

  function automatic int busy_lows(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (cap_busy[i] !== 1'b1) c++;
    return c;
  endfunction

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[i]   = tx;
      cap_fd[i]   = frame_done;
      cap_busy[i] = busy;
      @(negedge clk);
    end
  endtask

  task automatic wait_pop(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (fifo_pop === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    fq.push_back(8'hA5);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1) begin
        fails++; $display("FAIL reset_tx: got %b want 1", tx);
      end
      tests++;
      if (fifo_pop !== 1'b0) begin
        fails++; $display("FAIL reset_pop: got %b want 0", fifo_pop);
      end
      tests++;
      if (busy !== 1'b0) begin
        fails++; $display("FAIL reset_busy: got %b want 0", busy);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    bit f;
    int p0;
    p0 = pops;
    enable = 1'b1;
    wait_pop(f);
    tests++;
    if (!f) begin
      fails++; $display("FAIL single_pop_seen: got 0 want 1");
    end
    @(negedge clk);
    tests++;
    if (fifo_pop !== 1'b0 || tx !== 1'b1) begin
      fails++; $display("FAIL single_load: pop %b tx %b want 0 1", fifo_pop, tx);
    end
    @(negedge clk);
    capture(FL);
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (bit_seen(b) !== exp_bit(8'hA5, b)) begin
        fails++;
        $display("FAIL single_bit%0d: got %b want %b", b, bit_seen(b), exp_bit(8'hA5, b));
      end
    end
    tests++;
    if (fd_count(FL) != 1 || fd_last(FL) != FL-1) begin
      fails++;
      $display("FAIL single_done: count %0d at %0d want 1 at %0d", fd_count(FL), fd_last(FL), FL-1);
    end
    tests++;
    if (busy_lows(FL) != 0) begin
      fails++; $display("FAIL single_busy: %0d low cycles want 0", busy_lows(FL));
    end
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL single_idle: tx %b busy %b done %b want 1 0 0", tx, busy, frame_done);
    end
    repeat (8) @(negedge clk);
    tests++;
    if (pops - p0 != 1) begin
      fails++; $display("FAIL single_pops: got %0d want 1", pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    bit f;
    int p0;
    p0 = pops;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    wait_pop(f);
    tests++;
    if (!f) begin
      fails++; $display("FAIL b2b_pop_seen: got 0 want 1");
    end
    @(negedge clk);
    @(negedge clk);
    capture(FL);
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (bit_seen(b) !== exp_bit(8'h00, b)) begin
        fails++;
        $display("FAIL b2b_first_bit%0d: got %b want %b", b, bit_seen(b), exp_bit(8'h00, b));
      end
    end
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
      fails++; $display("FAIL b2b_gap_idle: tx %b busy %b pop %b want 1 0 0", tx, busy, fifo_pop);
    end
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b1 || fifo_pop !== 1'b1) begin
      fails++; $display("FAIL b2b_gap_pop: tx %b busy %b pop %b want 1 1 1", tx, busy, fifo_pop);
    end
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b1 || fifo_pop !== 1'b0) begin
      fails++; $display("FAIL b2b_gap_load: tx %b busy %b pop %b want 1 1 0", tx, busy, fifo_pop);
    end
    @(negedge clk);
    capture(FL);
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (bit_seen(b) !== exp_bit(8'hFF, b)) begin
        fails++;
        $display("FAIL b2b_second_bit%0d: got %b want %b", b, bit_seen(b), exp_bit(8'hFF, b));
      end
    end
    repeat (10) @(negedge clk);
    tests++;
    if (pops - p0 != 2) begin
      fails++; $display("FAIL b2b_pops: got %0d want 2", pops - p0);
    end
  endtask

  task automatic test_enable();
    bit f;
    int p0;
    p0 = pops;
    enable = 1'b0;
    fq.push_back(8'h55);
    fq.push_back(8'h66);
    repeat (20) @(negedge clk);
    tests++;
    if (pops != p0 || tx !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL en_off: pops %0d tx %b busy %b want 0 1 0", pops - p0, tx, busy);
    end
    enable = 1'b1;
    wait_pop(f);
    tests++;
    if (!f) begin
      fails++; $display("FAIL en_pop_seen: got 0 want 1");
    end
    @(negedge clk);
    @(negedge clk);
    repeat (3 * CPB) @(negedge clk);
    enable = 1'b0;
    capture(FL - 3 * CPB);
    tests++;
    if (fd_count(FL - 3*CPB) != 1 || fd_last(FL - 3*CPB) != FL - 3*CPB - 1) begin
      fails++;
      $display("FAIL en_drop_done: count %0d at %0d want 1 at %0d",
               fd_count(FL - 3*CPB), fd_last(FL - 3*CPB), FL - 3*CPB - 1);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (pops - p0 != 1 || tx !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL en_drop_after: pops %0d tx %b busy %b want 1 1 0", pops - p0, tx, busy);
    end
    fq.delete();
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit f;
    int p0;
    fq.push_back(8'h3C);
    wait_pop(f);
    tests++;
    if (!f) begin
      fails++; $display("FAIL rmid_pop_seen: got 0 want 1");
    end
    @(negedge clk);
    @(negedge clk);
    repeat (4 * CPB + 1) @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin
      fails++; $display("FAIL rmid_bit3: got %b want 1", tx);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL rmid_abort: tx %b busy %b pop %b done %b want 1 0 0 0", tx, busy, fifo_pop, frame_done);
    end
    rst = 1'b0;
    p0 = pops;
    repeat (20) @(negedge clk);
    tests++;
    if (pops != p0 || tx !== 1'b1) begin
      fails++; $display("FAIL rmid_empty: pops %0d tx %b want 0 1", pops - p0, tx);
    end
    fq.push_back(8'hAA);
    wait_pop(f);
    tests++;
    if (!f) begin
      fails++; $display("FAIL rmid_repop: got 0 want 1");
    end
    @(negedge clk);
    @(negedge clk);
    capture(FL);
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (bit_seen(b) !== exp_bit(8'hAA, b)) begin
        fails++;
        $display("FAIL rmid_bit%0d: got %b want %b", b, bit_seen(b), exp_bit(8'hAA, b));
      end
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    bit f;
    fq.push_back(8'hA5);
    fq.push_back(8'h07);
    wait_pop(f);
    tests++;
    if (!f) begin
      fails++; $display("FAIL par_pop_seen: got 0 want 1");
    end
    @(negedge clk);
    @(negedge clk);
    capture(FL);
    tests++;
    if (bit_seen(9) !== 1'b0) begin
      fails++; $display("FAIL par_a5: got %b want 0", bit_seen(9));
    end
    tests++;
    if (fd_last(FL) != 43) begin
      fails++; $display("FAIL par_len: done at %0d want 43", fd_last(FL));
    end
    repeat (3) @(negedge clk);
    capture(FL);
    tests++;
    if (bit_seen(9) !== 1'b1) begin
      fails++; $display("FAIL par_07: got %b want 1", bit_seen(9));
    end
    tests++;
    if (bit_seen(10) !== 1'b1) begin
      fails++; $display("FAIL par_stop: got %b want 1", bit_seen(10));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_enable();
    test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
